// File: rtl/clic_arb_pkg.sv
// -----------------------------------------------------------------------------
// clic_arb_pkg
// Shared types and helpers for the CLIC interrupt arbiter.
//   cand_t        : one arbitration candidate {valid, priv, ctl, shv, id}
//   arb_state_e   : delivery handshake states
//   normalise_ctl : left-aligned clicintctl with unimplemented low bits set
//   level_of      : interrupt level from normalised ctl and cliccfg.nlbits
//   sort_key      : MSB-first arbitration key {priv, ctl, id}
// -----------------------------------------------------------------------------
package clic_arb_pkg;

    // Wide enough for any supported source count; the top slices it down.
    localparam int unsigned MaxIdWidth = 16;
    localparam int unsigned KeyWidth   = MaxIdWidth + 10;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            priv;
        logic [7:0]            ctl;
        logic                  shv;
        logic [MaxIdWidth-1:0] id;
    } cand_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAck
    } arb_state_e;

    function automatic logic [7:0] normalise_ctl(input logic [7:0]  ctl,
                                                 input int unsigned intctlbits);
        logic [7:0] fill;
        fill = 8'hFF >> intctlbits;
        return ctl | fill;
    endfunction

    // nlbits above 8 saturates; nlbits of 0 yields level 255.
    function automatic logic [7:0] level_of(input logic [7:0] ctl,
                                            input logic [3:0] nlbits);
        logic [3:0] n;
        logic [7:0] fill;
        n    = (nlbits > 4'd8) ? 4'd8 : nlbits;
        fill = 8'hFF >> n;
        return ctl | fill;
    endfunction

    function automatic logic [KeyWidth-1:0] sort_key(input cand_t c);
        return {c.priv, c.ctl, c.id};
    endfunction

endpackage

// File: rtl/clic_arb_node.sv
// -----------------------------------------------------------------------------
// clic_arb_node
// Two-input arbitration node of the selection tree.
//   a_i   : candidate from the lower-index subtree
//   b_i   : candidate from the higher-index subtree
//   win_o : the valid candidate with the larger {priv, ctl, id} key
// -----------------------------------------------------------------------------
module clic_arb_node
    import clic_arb_pkg::*;
(
    input  cand_t a_i,
    input  cand_t b_i,
    output cand_t win_o
);

    logic pick_b;

    always_comb begin
        pick_b = b_i.valid & (~a_i.valid | (sort_key(b_i) > sort_key(a_i)));
        win_o  = pick_b ? b_i : a_i;
    end

endmodule

// File: rtl/clic_irq_arbiter.sv
// -----------------------------------------------------------------------------
// clic_irq_arbiter
// Selects the highest-ranked pending+enabled CLIC interrupt, applies the
// per-privilege level threshold and delivers it to the hart over a registered
// valid/ready handshake. Accepted edge-triggered sources get a one-cycle
// one-hot pending-clear pulse.
//
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   ip_i, ie_i                       per-source pending / enable
//   ctl_i                            clicintctl, byte i = source i
//   mode_i, shv_i, edge_i            clicintattr fields per source
//   nlbits_i, nmbits_i               cliccfg fields
//   mthresh_i, sthresh_i             M / S level thresholds
//   irq_valid_o, irq_ready_i         request handshake to the hart
//   irq_id_o, irq_level_o,
//   irq_shv_o, irq_priv_o            attributes of the request
//   clr_o                            one-hot pending-clear pulse
//
// Build option:
//   CLIC_ARB_PIPE_EN  register stage half-way up the selection tree
//                     (2-cycle selection latency; withdraw stays 1 cycle)
// -----------------------------------------------------------------------------
module clic_irq_arbiter
    import clic_arb_pkg::*;
#(
    parameter int unsigned N_SOURCE   = 256,
    parameter int unsigned INTCTLBITS = 8,
    parameter int unsigned ID_WIDTH   = $clog2(N_SOURCE)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_SOURCE-1:0]     ip_i,
    input  logic [N_SOURCE-1:0]     ie_i,
    input  logic [N_SOURCE*8-1:0]   ctl_i,
    input  logic [N_SOURCE*2-1:0]   mode_i,
    input  logic [N_SOURCE-1:0]     shv_i,
    input  logic [N_SOURCE-1:0]     edge_i,
    input  logic [3:0]              nlbits_i,
    input  logic [1:0]              nmbits_i,
    input  logic [7:0]              mthresh_i,
    input  logic [7:0]              sthresh_i,
    output logic                    irq_valid_o,
    input  logic                    irq_ready_i,
    output logic [ID_WIDTH-1:0]     irq_id_o,
    output logic [7:0]              irq_level_o,
    output logic                    irq_shv_o,
    output logic [1:0]              irq_priv_o,
    output logic [N_SOURCE-1:0]     clr_o
);

    localparam int TreeDepth = $clog2(N_SOURCE);
    // Registered tree level when the pipeline option is built in.
    localparam int PipeLvl   = TreeDepth - TreeDepth / 2;

    // -------------------------------------------------------------------------
    // Leaf candidates
    // -------------------------------------------------------------------------
    logic [N_SOURCE-1:0] cand_live;
    cand_t               leaf [N_SOURCE];

    assign cand_live = ip_i & ie_i;

    always_comb begin
        for (int i = 0; i < N_SOURCE; i++) begin
            leaf[i].valid = cand_live[i];
            leaf[i].priv  = (nmbits_i == 2'd0) ? 2'b11 : mode_i[2*i +: 2];
            leaf[i].ctl   = normalise_ctl(ctl_i[8*i +: 8], INTCTLBITS);
            leaf[i].shv   = shv_i[i];
            leaf[i].id    = MaxIdWidth'(i);
        end
    end

    // -------------------------------------------------------------------------
    // Selection tree, built from the leaves (lv = TreeDepth) up to the root
    // (lv = 0). Each level exposes 'fwd', the value its parent level consumes.
    // -------------------------------------------------------------------------
    for (genvar lv = TreeDepth; lv >= 0; lv = lv - 1) begin : g_lvl
        localparam int W = 1 << lv;

        cand_t raw [W];
        cand_t fwd [W];

        if (lv == TreeDepth) begin : g_leaf
            for (genvar j = 0; j < W; j++) begin : g_n
                assign raw[j] = leaf[j];
            end
        end else begin : g_node
            for (genvar j = 0; j < W; j++) begin : g_n
                clic_arb_node u_node (
                    .a_i   (g_lvl[lv+1].fwd[2*j]),
                    .b_i   (g_lvl[lv+1].fwd[2*j+1]),
                    .win_o (raw[j])
                );
            end
        end

`ifdef CLIC_ARB_PIPE_EN
        if (lv == PipeLvl) begin : g_pipe
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int k = 0; k < W; k++) fwd[k] <= '0;
                end else begin
                    for (int k = 0; k < W; k++) fwd[k] <= raw[k];
                end
            end
        end else begin : g_comb
            assign fwd = raw;
        end
`else
        assign fwd = raw;
`endif
    end

    // -------------------------------------------------------------------------
    // Threshold on the overall winner
    // -------------------------------------------------------------------------
    cand_t                root;
    logic [TreeDepth-1:0] root_idx;
    logic [7:0]           win_level;
    logic [7:0]           win_thresh;
    logic                 fwd_ok;

    assign root      = g_lvl[0].fwd[0];
    assign root_idx  = root.id[TreeDepth-1:0];
    assign win_level = level_of(root.ctl, nlbits_i);

    always_comb begin
        case (root.priv)
            2'b11:   win_thresh = mthresh_i;
            2'b01:   win_thresh = sthresh_i;
            default: win_thresh = 8'h00;
        endcase
    end

    // The live check stops a stale pipelined winner from being loaded after
    // its source has already dropped.
    assign fwd_ok = root.valid & cand_live[root_idx] & (win_level > win_thresh);

    // -------------------------------------------------------------------------
    // Delivery handshake
    // -------------------------------------------------------------------------
    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]          level_q, level_d;
    logic [7:0]          ctl_q, ctl_d;
    logic                shv_q, shv_d;
    logic [1:0]          priv_q, priv_d;
    logic [N_SOURCE-1:0] clr_q, clr_d;
    cand_t               held;
    logic                load;

    always_comb begin
        held.valid = 1'b1;
        held.priv  = priv_q;
        held.ctl   = ctl_q;
        held.shv   = shv_q;
        held.id    = MaxIdWidth'(id_q);
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        level_d = level_q;
        ctl_d   = ctl_q;
        shv_d   = shv_q;
        priv_d  = priv_q;
        clr_d   = '0;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fwd_ok) begin
                    load    = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Accept beats withdraw; withdraw beats preemption.
                if (irq_ready_i) begin
                    state_d = StAck;
                    if (edge_i[id_q]) clr_d[id_q] = 1'b1;
                end else if (!cand_live[id_q]) begin
                    state_d = StIdle;
                end else if (fwd_ok && (sort_key(root) > sort_key(held))) begin
                    load = 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            id_d    = root.id[ID_WIDTH-1:0];
            level_d = win_level;
            ctl_d   = root.ctl;
            shv_d   = root.shv;
            priv_d  = root.priv;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            id_q    <= '0;
            level_q <= '0;
            ctl_q   <= '0;
            shv_q   <= 1'b0;
            priv_q  <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            level_q <= level_d;
            ctl_q   <= ctl_d;
            shv_q   <= shv_d;
            priv_q  <= priv_d;
            clr_q   <= clr_d;
        end
    end

    assign irq_valid_o = (state_q == StReq);
    assign irq_id_o    = id_q;
    assign irq_level_o = level_q;
    assign irq_shv_o   = shv_q;
    assign irq_priv_o  = priv_q;
    assign clr_o       = clr_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_clic_irq_arbiter
// Directed bench for clic_irq_arbiter with 32 sources. Inputs are driven just
// after a rising edge and outputs are sampled 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_clic_irq_arbiter;

    localparam int unsigned NSrc = 32;
    localparam int unsigned IdW  = $clog2(NSrc);
`ifdef CLIC_ARB_PIPE_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic [NSrc-1:0]   ip;
    logic [NSrc-1:0]   ie;
    logic [NSrc*8-1:0] ctl;
    logic [NSrc*2-1:0] mode;
    logic [NSrc-1:0]   shv;
    logic [NSrc-1:0]   edge_v;
    logic [3:0]        nlbits;
    logic [1:0]        nmbits;
    logic [7:0]        mthresh;
    logic [7:0]        sthresh;
    logic              irq_valid;
    logic              irq_ready;
    logic [IdW-1:0]    irq_id;
    logic [7:0]        irq_level;
    logic              irq_shv;
    logic [1:0]        irq_priv;
    logic [NSrc-1:0]   clr;

    int n_checks = 0;
    int n_fail   = 0;

    clic_irq_arbiter #(
        .N_SOURCE   (NSrc),
        .INTCTLBITS (8),
        .ID_WIDTH   (IdW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ip_i        (ip),
        .ie_i        (ie),
        .ctl_i       (ctl),
        .mode_i      (mode),
        .shv_i       (shv),
        .edge_i      (edge_v),
        .nlbits_i    (nlbits),
        .nmbits_i    (nmbits),
        .mthresh_i   (mthresh),
        .sthresh_i   (sthresh),
        .irq_valid_o (irq_valid),
        .irq_ready_i (irq_ready),
        .irq_id_o    (irq_id),
        .irq_level_o (irq_level),
        .irq_shv_o   (irq_shv),
        .irq_priv_o  (irq_priv),
        .clr_o       (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [1:0] m, input logic [7:0] c);
        mode[2*s +: 2] = m;
        ctl[8*s +: 8]  = c;
    endtask

    task automatic quiesce();
        ip        = '0;
        irq_ready = 1'b0;
        repeat (4) tick();
        ctl     = '0;
        mode    = {NSrc{2'b11}};
        shv     = '0;
        edge_v  = '0;
        nlbits  = 4'd8;
        nmbits  = 2'd2;
        mthresh = 8'h00;
        sthresh = 8'h00;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ip        = '0;
        ie        = '1;
        ctl       = '0;
        mode      = {NSrc{2'b11}};
        shv       = '0;
        edge_v    = '0;
        nlbits    = 4'd8;
        nmbits    = 2'd2;
        mthresh   = 8'h00;
        sthresh   = 8'h00;
        irq_ready = 1'b0;
        ip[7]     = 1'b1;
        set_src(7, 2'b11, 8'hFF);
        repeat (3) tick();
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", irq_valid); end
        n_checks++; if (irq_id !== '0) begin n_fail++; $display("FAIL reset_id got %0d want 0", irq_id); end
        n_checks++; if (irq_level !== 8'h00) begin n_fail++; $display("FAIL reset_level got %h want 00", irq_level); end
        n_checks++; if (irq_shv !== 1'b0) begin n_fail++; $display("FAIL reset_shv got %b want 0", irq_shv); end
        n_checks++; if (irq_priv !== 2'b00) begin n_fail++; $display("FAIL reset_priv got %b want 00", irq_priv); end
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL reset_clr got %h want 0", clr); end
        rst_n = 1'b1;
        quiesce();
    endtask

    task automatic test_priv_order();
        set_src(7, 2'b11, 8'hFF);
        set_src(5, 2'b01, 8'hFF);
        ip[7] = 1'b1;
        ip[5] = 1'b1;
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL prio_pre_valid got %b want 0", irq_valid); end
        for (int k = 0; k < Lat - 1; k++) begin
            tick();
            n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL prio_pipe_valid got %b want 0", irq_valid); end
        end
        tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL prio_valid got %b want 1", irq_valid); end
        n_checks++; if (irq_id !== 5'd7) begin n_fail++; $display("FAIL prio_id got %0d want 7", irq_id); end
        n_checks++; if (irq_priv !== 2'b11) begin n_fail++; $display("FAIL prio_priv got %b want 11", irq_priv); end
        n_checks++; if (irq_level !== 8'hFF) begin n_fail++; $display("FAIL prio_level got %h want ff", irq_level); end
        irq_ready = 1'b1;
        tick();
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL prio_ack_valid got %b want 0", irq_valid); end
        irq_ready = 1'b0;
        ip[7]     = 1'b0;
        repeat (2) tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL prio_next_valid got %b want 1", irq_valid); end
        n_checks++; if (irq_id !== 5'd5) begin n_fail++; $display("FAIL prio_next_id got %0d want 5", irq_id); end
        n_checks++; if (irq_priv !== 2'b01) begin n_fail++; $display("FAIL prio_next_priv got %b want 01", irq_priv); end
        quiesce();
    endtask

    task automatic test_id_tiebreak();
        set_src(10, 2'b11, 8'h80);
        set_src(12, 2'b11, 8'h80);
        ip[10] = 1'b1;
        ip[12] = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (irq_id !== 5'd12) begin n_fail++; $display("FAIL tie_id got %0d want 12", irq_id); end
        n_checks++; if (irq_level !== 8'h80) begin n_fail++; $display("FAIL tie_level got %h want 80", irq_level); end
        set_src(10, 2'b11, 8'hC0);
        repeat (Lat) tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL preempt_valid got %b want 1", irq_valid); end
        n_checks++; if (irq_id !== 5'd10) begin n_fail++; $display("FAIL preempt_id got %0d want 10", irq_id); end
        n_checks++; if (irq_level !== 8'hC0) begin n_fail++; $display("FAIL preempt_level got %h want c0", irq_level); end
        quiesce();
    endtask

    task automatic test_threshold();
        set_src(7, 2'b11, 8'h80);
        mthresh = 8'h80;
        ip[7]   = 1'b1;
        repeat (Lat + 1) tick();
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL mth_eq_valid got %b want 0", irq_valid); end
        mthresh = 8'h7F;
        tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL mth_below_valid got %b want 1", irq_valid); end
        n_checks++; if (irq_level !== 8'h80) begin n_fail++; $display("FAIL mth_level got %h want 80", irq_level); end
        quiesce();
        set_src(4, 2'b01, 8'h60);
        sthresh = 8'h60;
        ip[4]   = 1'b1;
        repeat (Lat + 1) tick();
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL sth_eq_valid got %b want 0", irq_valid); end
        sthresh = 8'h5F;
        tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL sth_below_valid got %b want 1", irq_valid); end
        n_checks++; if (irq_priv !== 2'b01) begin n_fail++; $display("FAIL sth_priv got %b want 01", irq_priv); end
        quiesce();
        // nlbits=2: level = 0x40 | 0x3F
        set_src(9, 2'b11, 8'h40);
        nlbits = 4'd2;
        ip[9]  = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (irq_level !== 8'h7F) begin n_fail++; $display("FAIL nlbits_level got %h want 7f", irq_level); end
        quiesce();
    endtask

    task automatic test_nmbits();
        nmbits = 2'd0;
        set_src(7, 2'b00, 8'hFF);
        set_src(5, 2'b11, 8'h10);
        ip[7] = 1'b1;
        ip[5] = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (irq_id !== 5'd7) begin n_fail++; $display("FAIL nmbits_id got %0d want 7", irq_id); end
        n_checks++; if (irq_priv !== 2'b11) begin n_fail++; $display("FAIL nmbits_priv got %b want 11", irq_priv); end
        quiesce();
    endtask

    task automatic test_edge_clear();
        set_src(3, 2'b11, 8'hFF);
        edge_v[3] = 1'b1;
        ip[3]     = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL edge_req_clr got %h want 0", clr); end
        irq_ready = 1'b1;
        tick();
        n_checks++; if (clr !== 32'h0000_0008) begin n_fail++; $display("FAIL edge_ack_clr got %h want 8", clr); end
        irq_ready = 1'b0;
        ip[3]     = 1'b0;
        tick();
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL edge_after_clr got %h want 0", clr); end
        quiesce();
        set_src(3, 2'b11, 8'hFF);
        ip[3] = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL level_req_valid got %b want 1", irq_valid); end
        irq_ready = 1'b1;
        tick();
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL level_ack_clr got %h want 0", clr); end
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL level_ack_valid got %b want 0", irq_valid); end
        quiesce();
    endtask

    task automatic test_withdraw();
        set_src(7, 2'b11, 8'hFF);
        edge_v[7] = 1'b1;
        ip[7]     = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL wd_req_valid got %b want 1", irq_valid); end
        ip[7] = 1'b0;
        tick();
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL wd_valid got %b want 0", irq_valid); end
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL wd_clr got %h want 0", clr); end
        tick();
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL wd_clr2 got %h want 0", clr); end
        ip[7] = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL wdr_req_valid got %b want 1", irq_valid); end
        ip[7]     = 1'b0;
        irq_ready = 1'b1;
        tick();
        n_checks++; if (clr !== 32'h0000_0080) begin n_fail++; $display("FAIL wdr_ack_clr got %h want 80", clr); end
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL wdr_ack_valid got %b want 0", irq_valid); end
        irq_ready = 1'b0;
        tick();
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL wdr_after_clr got %h want 0", clr); end
        quiesce();
    endtask

    task automatic test_reset_mid();
        set_src(7, 2'b11, 8'hFF);
        shv[7]    = 1'b1;
        edge_v[7] = 1'b1;
        ip[7]     = 1'b1;
        repeat (Lat) tick();
        n_checks++; if (irq_shv !== 1'b1) begin n_fail++; $display("FAIL rm_req_shv got %b want 1", irq_shv); end
        rst_n     = 1'b0;
        irq_ready = 1'b1;
        tick();
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b want 0", irq_valid); end
        n_checks++; if (irq_id !== '0) begin n_fail++; $display("FAIL rm_id got %0d want 0", irq_id); end
        n_checks++; if (irq_level !== 8'h00) begin n_fail++; $display("FAIL rm_level got %h want 00", irq_level); end
        n_checks++; if (irq_shv !== 1'b0) begin n_fail++; $display("FAIL rm_shv got %b want 0", irq_shv); end
        n_checks++; if (irq_priv !== 2'b00) begin n_fail++; $display("FAIL rm_priv got %b want 00", irq_priv); end
        n_checks++; if (clr !== '0) begin n_fail++; $display("FAIL rm_clr got %h want 0", clr); end
        rst_n = 1'b1;
        quiesce();
    endtask

    initial begin
        test_reset();
        test_priv_order();
        test_id_tiebreak();
        test_threshold();
        test_nmbits();
        test_edge_clear();
        test_withdraw();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
